// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle shifter.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned STEP_DEF  = 8;
  // Only b[4:0] is a real shift amount; anything above saturates.
  localparam int unsigned AMT_W     = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves din by amt bits (0..STEP) per op.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AW    = AMT_W
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] dout
);

  // Logical shifts zero-fill, arithmetic right sign-fills; illegal op passes through.
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = din << amt;
      OP_SRL:  dout = din >> amt;
      OP_SRA:  dout = $signed(din) >>> amt;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative shifter: accepts one request, shifts up to STEP bits per cycle,
// and holds the result in DONE until the consumer takes it.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned STEP  = STEP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  localparam int unsigned       KW     = AMT_W + 1;
  localparam logic [KW-1:0]     STEP_K = KW'(STEP);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;

  op_e                op_in;
  logic [AMT_W-1:0]   amt;
  logic               sat;
  logic               last_step;
  logic [AMT_W-1:0]   k;
  logic [WIDTH-1:0]   step_out;

  assign op_in = op_e'(op);
  assign amt   = b[AMT_W-1:0];
  assign sat   = |b[WIDTH-1:AMT_W];

  // Per-cycle shift amount k = min(rem, STEP); last_step when this step finishes the job.
  always_comb begin
    last_step = ({1'b0, rem_q} <= STEP_K);
    k         = last_step ? rem_q : STEP_K[AMT_W-1:0];
  end

  shift_step #(
    .WIDTH (WIDTH),
    .AW    (AMT_W)
  ) u_step (
    .op   (op_q),
    .din  (val_q),
    .amt  (k),
    .dout (step_out)
  );

  // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op_in;
          err_d = (op_in == OP_ILL);
          val_d = a;
          rem_d = '0;
          if (op_in == OP_ILL || amt == '0) begin
            state_d = DONE;
          end else if (sat) begin
            state_d = DONE;
            val_d   = (op_in == OP_SRA) ? {WIDTH{a[WIDTH-1]}} : '0;
          end else begin
            state_d = SHIFT;
            rem_d   = amt;
          end
          // Saturation overrides a legal nonzero-looking amt in b[4:0].
          if (sat && op_in != OP_ILL) begin
            state_d = DONE;
            rem_d   = '0;
            val_d   = (op_in == OP_SRA) ? {WIDTH{a[WIDTH-1]}} : '0;
          end
        end
      end
      SHIFT: begin
        val_d = step_out;
        rem_d = rem_q - k;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      val_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = val_q;
  assign err       = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written
// corner sequences and randomized requests against a behavioural model.
module tb_shift_seq_ctrl;

  localparam int STEP = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        err;
  logic        busy;

  int n_chk;
  int n_fail;

  shift_seq_ctrl #(
    .WIDTH (32),
    .STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result/err/latency straight from the shift rules.
  task automatic model(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output logic [31:0] res, output logic e, output int lat);
    int unsigned amt;
    amt = b_i % 32;
    e   = (op_i == 2'b11);
    lat = 1;
    if (op_i == 2'b11) begin
      res = a_i;
    end else if (b_i > 32'd31) begin
      res = (op_i == 2'b10 && a_i[31]) ? 32'hFFFF_FFFF : 32'h0;
    end else if (amt == 0) begin
      res = a_i;
    end else begin
      case (op_i)
        2'b00:   res = a_i << amt;
        2'b01:   res = a_i >> amt;
        default: res = $signed(a_i) >>> amt;
      endcase
      lat = 1 + (int'(amt) + STEP - 1) / STEP;
    end
  endtask

  // One full request: accept, scramble inputs, wait for result, stall, handshake.
  task automatic run(input string nm, input logic [1:0] op_i, input logic [31:0] a_i,
                     input logic [31:0] b_i, input logic [31:0] exp_res, input logic exp_err,
                     input int exp_lat, input int hold);
    int lat;
    check({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = op_i;
    a  = a_i;
    b  = b_i;
    tick();
    in_valid = 1'b0;
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
    end
    check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    check({nm, ".result"}, result, exp_res);
    check({nm, ".err"}, {31'd0, err}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      tick();
      check({nm, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({nm, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({nm, ".hold_result"}, result, exp_res);
      check({nm, ".hold_err"}, {31'd0, err}, {31'd0, exp_err});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, ".valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({nm, ".ready_rise"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    check({nm, ".result"}, result, 32'd0);
    check({nm, ".err"}, {31'd0, err}, 32'd0);
    check({nm, ".busy"}, {31'd0, busy}, 32'd0);
    check({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t        tbl[11];
  logic [31:0] m_res;
  logic        m_err;
  int          m_lat;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;

    tbl[0]  = '{2'b10, 32'h8000_0000, 32'd4,      32'hF800_0000, 1'b0, 2};
    tbl[1]  = '{2'b01, 32'hF000_000F, 32'd31,     32'h0000_0001, 1'b0, 5};
    tbl[2]  = '{2'b00, 32'h0000_0001, 32'd8,      32'h0000_0100, 1'b0, 2};
    tbl[3]  = '{2'b10, 32'h8000_0001, 32'h20,     32'hFFFF_FFFF, 1'b0, 1};
    tbl[4]  = '{2'b00, 32'hFFFF_FFFF, 32'h100,    32'h0000_0000, 1'b0, 1};
    tbl[5]  = '{2'b11, 32'h1234_5678, 32'd3,      32'h1234_5678, 1'b1, 1};
    tbl[6]  = '{2'b00, 32'hDEAD_BEEF, 32'd0,      32'hDEAD_BEEF, 1'b0, 1};
    tbl[7]  = '{2'b01, 32'h8000_0000, 32'd9,      32'h0040_0000, 1'b0, 3};
    tbl[8]  = '{2'b10, 32'h8000_1234, 32'd16,     32'hFFFF_8000, 1'b0, 3};
    tbl[9]  = '{2'b01, 32'hFFFF_FFFF, 32'h21,     32'h0000_0000, 1'b0, 1};
    tbl[10] = '{2'b10, 32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0000, 1'b0, 1};

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
          tbl[i].res, tbl[i].err, tbl[i].lat, 0);
    end

    // Consumer stalls three cycles in DONE.
    run("stall", 2'b01, 32'hF000_000F, 32'd31, 32'h0000_0001, 1'b0, 5, 3);

    // Reset mid-SHIFT aborts immediately; requests during reset are ignored.
    in_valid = 1'b1;
    op = 2'b01;
    a  = 32'hF000_000F;
    b  = 32'd31;
    tick();
    in_valid = 1'b0;
    tick();
    check("shift_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_shift");
    in_valid = 1'b1;
    tick();
    check_reset_outputs("rst_hold");
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    run("post_rst", 2'b01, 32'h0000_0100, 32'd4, 32'h0000_0010, 1'b0, 2, 0);

    // Reset while a result waits in DONE drops it without a handshake.
    in_valid = 1'b1;
    op = 2'b11;
    a  = 32'hCAFE_F00D;
    b  = 32'd1;
    tick();
    in_valid = 1'b0;
    check("done_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 200; i++) begin
      r_op = 2'($urandom);
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = $urandom;
        1:       r_b = 32'($urandom_range(0, 8));
        default: r_b = 32'($urandom_range(0, 40));
      endcase
      model(r_op, r_a, r_b, m_res, m_err, m_lat);
      run($sformatf("rnd%0d", i), r_op, r_a, r_b, m_res, m_err, m_lat, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
